// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard at the ID stage: tracks in-flight destinations in a DEPTH-entry shift pipe.
// Optional stall/flush performance counters are enabled by defining HAZARD_SCOREBOARD_PERF_EN.
module hazard_scoreboard #(
    parameter int NREG       = 32,
    parameter int DEPTH      = 3,
    parameter int NSRC       = 2,
    parameter int LOAD_STAGE = 1,
    parameter int ZERO_REG   = 31,
    localparam int AW = $clog2(NREG),
    localparam int FW = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic [AW-1:0]        id_rd,
    input  logic                 id_wr_en,
    input  logic                 id_is_load,
    input  logic                 hold,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC*FW-1:0]   fwd_sel,
    output logic [31:0]          stall_count,
    output logic [31:0]          flush_count
);

    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    logic [DEPTH-1:0]         ent_valid;
    logic [DEPTH-1:0]         ent_wr;
    logic [DEPTH-1:0]         ent_load;
    logic [DEPTH-1:0][AW-1:0] ent_rd;

    logic                     blocked;
    logic [NSRC*FW-1:0]       fwd_raw;
    logic                     hit;
    int                       hit_k;
    logic                     hit_load;

    logic                     bubble;
    logic                     new_valid;
    logic                     new_wr;
    logic                     new_load;
    logic [AW-1:0]            new_rd;

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        blocked  = 1'b0;
        fwd_raw  = '0;
        hit      = 1'b0;
        hit_k    = 0;
        hit_load = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            hit      = 1'b0;
            hit_k    = 0;
            hit_load = 1'b0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (id_src_used[i] && (id_src[i*AW +: AW] != ZR) && ent_valid[k] &&
                    ent_wr[k] && (ent_rd[k] == id_src[i*AW +: AW])) begin
                    hit      = 1'b1;
                    hit_k    = k;
                    hit_load = ent_load[k];
                end
            end
            if (hit) begin
                if (hit_load && (hit_k < LOAD_STAGE)) begin
                    blocked = 1'b1;
                end else if (hit_k < DEPTH - 1) begin
                    fwd_raw[i*FW +: FW] = FW'(hit_k + 1);
                end
            end
        end
    end

    assign stall   = id_valid & ~flush & blocked;
    assign fwd_sel = stall ? '0 : fwd_raw;

    assign bubble    = flush | stall;
    assign new_valid = id_valid & ~bubble;
    assign new_wr    = id_wr_en & (id_rd != ZR) & ~bubble;
    assign new_load  = id_is_load & ~bubble;
    assign new_rd    = bubble ? '0 : id_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid <= '0;
            ent_wr    <= '0;
            ent_load  <= '0;
            ent_rd    <= '0;
        end else if (!hold) begin
            ent_valid <= {ent_valid[DEPTH-2:0], new_valid};
            ent_wr    <= {ent_wr[DEPTH-2:0], new_wr};
            ent_load  <= {ent_load[DEPTH-2:0], new_load};
            ent_rd    <= {ent_rd[DEPTH-2:0], new_rd};
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!hold) begin
            if (stall) stall_cnt <= stall_cnt + 32'd1;
            if (flush) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign stall_count = stall_cnt;
    assign flush_count = flush_cnt;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard/forwarding unit for the pipelined CPU; successor to a fixed 5-stage, two-stage-forwarding hazard unit.
- Sits at the ID stage and tracks destination registers of in-flight instructions in a DEPTH-entry shift pipeline (entry 0 = EX).
- Per source operand, it decides each cycle whether to stall ID (one-cycle bubble) or select a forwarding stage.
- Generalised in pipeline depth, register count, load-result stage and number of source operands.

Parameters:
- NREG, 32, architectural register count; index width AW = $clog2(NREG).
- DEPTH, 3, tracked stages after ID (0=EX, 1=MEM, 2=WB); minimum 2.
- NSRC, 2, source operands checked per instruction.
- LOAD_STAGE, 1, stage after which load data exists; must be < DEPTH-1.
- ZERO_REG, 31, hard-wired zero register (XZR); never causes a hazard or forwards.

Ports:
- clk, in, 1, clock; all state on rising edge.
- reset, in, 1, asynchronous active-high reset.
- id_valid, in, 1, ID holds a real instruction.
- id_src, in, NSRC*AW, source register indices; operand i occupies bits [i*AW +: AW].
- id_src_used, in, NSRC, per-operand "really read" mask.
- id_rd, in, AW, destination register.
- id_wr_en, in, 1, instruction writes id_rd.
- id_is_load, in, 1, instruction is a load (LDUR).
- hold, in, 1, global freeze (e.g. memory wait).
- flush, in, 1, discard the ID instruction (branch taken in EX).
- stall, out, 1, hold PC and IF/ID, insert bubble.
- fwd_sel, out, NSRC*FW, FW = $clog2(DEPTH+1); 0 = register file, k+1 = result of entry k.
- stall_count, out, 32, stall cycles (optional feature).
- flush_count, out, 32, flush cycles (optional feature).

Behaviour:
- Entry fields: {valid, rd, wr, is_load}.
- Reset (async): all entries valid=0; stall=0 and fwd_sel=0 follow combinationally; counters=0.
- Match, per operand i: src used, src != ZERO_REG, entry valid, wr=1, rd==src.
- If several entries match, only the youngest (lowest index k) counts.
- Ready rule: ready_stage = LOAD_STAGE if is_load, else 0. The youngest match at k is forwardable iff k >= ready_stage.
- stall = id_valid & ~flush & (some operand has a non-forwardable youngest match).
- fwd_sel[i] = k+1 for a forwardable match with k < DEPTH-1.
- fwd_sel[i] = 0 when there is no match, or the match is at k = DEPTH-1 (register file is write-through).
- fwd_sel[i] = 0 whenever stall=1.
- Outputs are combinational from current state and ID inputs; latency 0.
- Update at clock edge, priority reset > hold > flush > stall > normal:
  - hold: all entries unchanged.
  - flush or stall: entries shift k→k+1; entry 0 gets a bubble (valid=0).
  - normal: shift; entry 0 = {id_valid, id_rd, id_wr_en & (id_rd != ZERO_REG), id_is_load}.
- Oldest entry (DEPTH-1) drops off each shift; no full/empty condition exists.
- Load-use with DEPTH=3, LOAD_STAGE=1: exactly one stall cycle, then fwd_sel=2 (MEM/WB).
- Reset mid-stall clears all entries; stall drops immediately (async).
- hold together with stall: stall stays asserted, no bubble is inserted, state is frozen.
- hold together with flush: flush is ignored until hold deasserts; upstream must keep flush high.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_PERF_EN.
- With macro: stall_count increments on each edge where stall=1 & ~hold; flush_count increments on each edge where flush=1 & ~hold. Both are 32-bit and wrap at 2^32-1 → 0; async reset to 0.
- Without macro: both ports tied to 0; no counter flops.

Test Plan:
- ALU→ALU back-to-back: ADD X1 then ADD X2,X1,X3 → stall=0, fwd_sel[0]=1; next instruction using X1 at gap 2 → fwd_sel=2; at gap 3 → 0.
- Load-use: LDUR X5 then ADD X6,X5,X5 → stall=1 for one cycle, bubble enters entry 0; next cycle stall=0, fwd_sel[0]=fwd_sel[1]=2.
- XZR: LDUR X31 followed by read of X31 → stall=0, fwd_sel=0; youngest-wins: ADD X4 then SUB X4 then read X4 → fwd_sel=1.
- Flush: flush=1 with a load-use pending in ID → stall=0, entry 0 bubble, no later forwarding to that rd.
- hold=1 for 3 cycles during load-use → stall stays 1, entries frozen; release → one bubble, then fwd_sel=2.
- Async reset asserted mid-stall → stall=0 immediately, all fwd_sel=0; with HAZARD_SCOREBOARD_PERF_EN, stall_count=0 and counts 5 after 5 load-use pairs.
